dest_sel_pipe: RTL
==================

Name: dest_sel_pipe

Overview:
- Parametrised destination-register selector and tracker for the pipelined datapath.
- Selects the write-back destination from rt, rd or the link register, using a 2-bit mode.
- Carries the selected destination and its write-valid bit through STAGES pipeline registers (EX/MEM/WB by default).
- Compares the in-flight destinations against the two source fields of the decoding instruction and reports hazards to the hazard/forwarding unit.

Parameters:
- ADDR_W, 5: register address width.
- STAGES, 3: number of tracked pipeline stages; index 0 is youngest (EX), STAGES-1 is oldest (WB); minimum 1.
- LINK_REG, 31: register number written by link (jal) instructions; must fit in ADDR_W bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rt  in  ADDR_W  rt field of the instruction in decode.
- rd  in  ADDR_W  rd field of the instruction in decode.
- sel_dest  in  2  destination mode: 00 rt, 01 rd, 10 LINK_REG, 11 no destination.
- reg_write_in  in  1  the decoded instruction writes the register file.
- stall  in  1  freeze the decode-to-stage-0 transfer.
- flush  in  1  kill the instruction entering stage 0.
- rs_chk  in  ADDR_W  rs source of the decoding instruction, used for hazard compare.
- rt_chk  in  ADDR_W  rt source of the decoding instruction, used for hazard compare.
- dest_out  out  STAGES*ADDR_W  registered destination per stage; stage i occupies bits [i*ADDR_W +: ADDR_W].
- valid_out  out  STAGES  registered write-valid per stage.
- hazard_rs  out  1  rs_chk matches a valid in-flight destination.
- hazard_rt  out  1  rt_chk matches a valid in-flight destination.
- hit_stage_rs  out  STAGES  one-hot; marks the youngest matching stage for rs, zero if no match.
- hit_stage_rt  out  STAGES  one-hot; marks the youngest matching stage for rt, zero if no match.

Behaviour:
- Reset, synchronous: all dest_out entries become 0 and all valid_out bits become 0. Hazard and hit outputs therefore read 0 in the cycle after reset. Reset overrides stall and flush. A reset asserted mid-stream discards every in-flight entry.
- Next-destination mux, combinational: sel 00 gives rt, 01 gives rd, 10 gives LINK_REG, 11 gives 0.
- Next-valid: reg_write_in AND (sel_dest != 11). This is further qualified by the zero filter when it is enabled (see Optional Feature).
- Normal edge (no stall, no flush): stage 0 loads the mux result and next-valid, and each stage i≥1 loads stage i-1. Latency from decode to stage k is k+1 cycles. The entry in stage STAGES-1 retires.
- Stall=1, flush=0:
  - Stage 0 holds its dest and valid.
  - Stage 1 receives a bubble (valid=0, dest=0).
  - Stages ≥2 advance normally.
  - With STAGES=1, stage 0 simply holds.
- Flush=1, with or without stall: stage 0 loads a bubble (valid=0, dest=0) and stages ≥1 advance normally. Flush has priority over stall.
- Hazard compare, combinational from registered state plus current rs_chk/rt_chk:
  - match_i = valid_out[i] AND dest_out[i]==chk.
  - hazard_x is the OR of all match_i.
  - hit_stage_x is a one-hot of the lowest matching index, so the youngest producer wins when several stages match.
- Stall and flush do not alter hazard outputs combinationally; they only take effect at the next edge.
- No wrap-around or overflow conditions exist; widths are fixed by ADDR_W.

Optional Feature:
- Macro: DEST_ZERO_FILTER_EN.
- Defined: next-valid is additionally ANDed with (mux result != 0), so writes to register 0 never enter the tracker. A check against register 0 therefore never produces a hazard.
- Undefined: register-0 destinations are tracked like any other, and a check against 0 can hit. Downstream logic is then responsible for ignoring those hits.

Test Plan (ADDR_W=5, STAGES=3, LINK_REG=31):
- Reset, then sel=01, rd=7, reg_write_in=1 for one cycle, then idle → dest_out stage0=7 valid=1 after edge 1; stage1 after edge 2; stage2 after edge 3; all valid=0 after edge 4.
- sel=10, reg_write_in=1, then rs_chk=31 → stage0 dest=31; hazard_rs=1, hit_stage_rs=001.
- Issue rt=5 (sel=00), then rd=5 (sel=01), then rs_chk=5 → stages 0 and 1 both hold 5; hit_stage_rs=001 and hazard_rs=1.
- Issue dest 9, then stall for 2 cycles → stage0 holds 9 valid; stage1 valid=0 during the stall; after release, 9 appears in stage1.
- stall=1 and flush=1 together with dest 12 in stage0 → next edge: stage0 valid=0, stage1 = 12 valid, no duplication of 12.
- Write to rd=0 with reg_write_in=1, then rt_chk=0 → with DEST_ZERO_FILTER_EN: valid_out=000, hazard_rt=0; without it: valid_out=001, hazard_rt=1.

Source files
------------

// File: rtl/dest_sel_pipe.sv
// Destination-register selector and in-flight destination tracker with hazard compare.
// Define DEST_ZERO_FILTER_EN to keep register-0 writes out of the tracker.
module dest_sel_pipe #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rt,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [1:0]               sel_dest,
  input  logic                     reg_write_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        rs_chk,
  input  logic [ADDR_W-1:0]        rt_chk,
  output logic [STAGES*ADDR_W-1:0] dest_out,
  output logic [STAGES-1:0]        valid_out,
  output logic                     hazard_rs,
  output logic                     hazard_rt,
  output logic [STAGES-1:0]        hit_stage_rs,
  output logic [STAGES-1:0]        hit_stage_rt
);

  logic [ADDR_W-1:0] dest_q [STAGES];
  logic [ADDR_W-1:0] dest_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  logic [ADDR_W-1:0] next_dest;
  logic              next_valid;

  always_comb begin
    unique case (sel_dest)
      2'b00:   next_dest = rt;
      2'b01:   next_dest = rd;
      2'b10:   next_dest = ADDR_W'(LINK_REG);
      default: next_dest = '0;
    endcase
  end

`ifdef DEST_ZERO_FILTER_EN
  assign next_valid = reg_write_in && (sel_dest != 2'b11) && (next_dest != '0);
`else
  assign next_valid = reg_write_in && (sel_dest != 2'b11);
`endif

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      dest_d[i] = dest_q[i];
    end
    valid_d = valid_q;

    if (flush) begin
      dest_d[0]  = '0;
      valid_d[0] = 1'b0;
    end else if (!stall) begin
      dest_d[0]  = next_dest;
      valid_d[0] = next_valid;
    end

    // A held stage 0 must not also be copied forward, so stage 1 takes a bubble on a pure stall.
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (stall && !flush && i == 1) begin
        dest_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else begin
        dest_d[i]  = dest_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        dest_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        dest_q[i] <= dest_d[i];
      end
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      dest_out[i*ADDR_W +: ADDR_W] = dest_q[i];
    end
  end

  assign valid_out = valid_q;

  logic [STAGES-1:0] match_rs;
  logic [STAGES-1:0] match_rt;

  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      match_rs[i] = valid_q[i] && (dest_q[i] == rs_chk);
      match_rt[i] = valid_q[i] && (dest_q[i] == rt_chk);
    end
  end

  assign hazard_rs = |match_rs;
  assign hazard_rt = |match_rt;

  // Walk oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    hit_stage_rs = '0;
    hit_stage_rt = '0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      if (match_rs[i]) begin
        hit_stage_rs    = '0;
        hit_stage_rs[i] = 1'b1;
      end
      if (match_rt[i]) begin
        hit_stage_rt    = '0;
        hit_stage_rt[i] = 1'b1;
      end
    end
  end

endmodule
